// File: rtl/pulse_train_gen_pkg.sv
// Shared constants for the pulse train generator: FSM state encoding,
// receiver debounce depth and a small helper for sizing the phase timer.
package pulse_train_gen_pkg;

    // 3-bit state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GUARD = 3'd1;
    localparam logic [2:0] ST_HIGH  = 3'd2;
    localparam logic [2:0] ST_LOW   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Shortest high/low phase the debounced receiver will still see
    localparam int DEBOUNCE_MIN = 3;

    // Largest of three phase lengths, used to size the shared timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// Down-counter with synchronous load. expire_o is registered and is high
// during the last cycle of a loaded interval, so the FSM can leave a phase
// on the same edge the interval ends.
module phase_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    output logic          expire_o
);

    logic [TW-1:0] cnt_q;
    logic          exp_q;

    // Load or count down; flag the cycle in which the count reaches 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            exp_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
            exp_q <= (load_val_i == TW'(1));
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
            exp_q <= (cnt_q == TW'(2));
        end else begin
            exp_q <= 1'b0;
        end
    end

    assign expire_o = exp_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Emits code_in clean fixed-width pulses on data_out after a low guard
// interval, then a one-cycle done. Outputs are decoded from the state
// register only, so there is no input-to-output combinational path.
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int HIGH_CYCLES  = 4,
    parameter int LOW_CYCLES   = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] code_in,
    output logic             ready,
    output logic             running,
    output logic             data_out,
    output logic             done
);

    localparam int TW = $clog2(max3(HIGH_CYCLES, LOW_CYCLES, GUARD_CYCLES) + 1);

    // Elaboration-time parameter sanity
    if (WIDTH < 1)        begin : g_bad_width $fatal(1, "WIDTH must be >= 1"); end
    if (HIGH_CYCLES < 1)  begin : g_bad_high  $fatal(1, "HIGH_CYCLES must be >= 1"); end
    if (LOW_CYCLES < 1)   begin : g_bad_low   $fatal(1, "LOW_CYCLES must be >= 1"); end
    if (GUARD_CYCLES < 1) begin : g_bad_guard $fatal(1, "GUARD_CYCLES must be >= 1"); end
    if (HIGH_CYCLES < DEBOUNCE_MIN || LOW_CYCLES < DEBOUNCE_MIN) begin : g_short_phase
        $warning("phase shorter than receiver debounce depth; pulses may be filtered");
    end

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_exp;

    phase_timer #(.TW(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_exp)
    );

    // Next-state, pulse count and timer load selection
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d  = code_in;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GUARD_CYCLES);
                    state_d  = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (tmr_exp) begin
                    if (count_q != '0) begin
                        tmr_load = 1'b1;
                        tmr_val  = TW'(HIGH_CYCLES);
                        state_d  = ST_HIGH;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_HIGH: begin
                if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(LOW_CYCLES);
                    state_d  = ST_LOW;
                end
            end
            ST_LOW: begin
                // count is nonzero here, so the decrement cannot wrap
                if (tmr_exp) begin
                    count_d = count_q - WIDTH'(1);
                    if (count_d != '0) begin
                        tmr_load = 1'b1;
                        tmr_val  = TW'(HIGH_CYCLES);
                        state_d  = ST_HIGH;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pulse counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign running  = (state_q == ST_GUARD) || (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign data_out = (state_q == ST_HIGH);
    assign done     = (state_q == ST_DONE);

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Digital-to-time stimulus generator: accepts an 8-bit code through a start/ready handshake and emits exactly that many clean, fixed-width pulses on a single serial output.
- It is the transmit-side counterpart of the time-to-digital front end (synchronizer → debounce → edge detector → counter).
- High and low phases are each at least as long as the receiver's debounce depth, so every emitted pulse survives debouncing.
- Used for on-chip loopback calibration and as a bench stimulus source.

## Interface
Parameters:
- WIDTH, 8, width of code_in; maximum pulse count 2^WIDTH-1
- HIGH_CYCLES, 4, clock cycles data_out is high per pulse (≥1; ≥3 when driving the debounced receiver)
- LOW_CYCLES, 4, clock cycles data_out is low between pulses (≥1; same constraint)
- GUARD_CYCLES, 2, low lead-in cycles before the first pulse (≥1)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only on an edge where ready=1
- code_in  input  WIDTH  number of pulses; latched on the accept edge
- ready  output  1  idle, can accept start
- running  output  1  burst in progress (guard, high and low phases)
- data_out  output  1  serial pulse output
- done  output  1  one-cycle pulse after the last low phase

## Operation
- States: IDLE, GUARD, HIGH, LOW, DONE. All outputs are decoded from registered state, so there are no combinational paths from inputs to outputs.
- IDLE: ready=1.
  - On start=1, latch code_in into the pulse counter, load the phase timer with GUARD_CYCLES, and go to GUARD.
- GUARD: data_out=0, running=1.
  - When the timer expires: go to HIGH if count≠0, otherwise go to DONE.
- HIGH: data_out=1, running=1. When the timer expires after HIGH_CYCLES, go to LOW.
- LOW: data_out=0, running=1. When the timer expires after LOW_CYCLES, decrement count.
  - Go to HIGH if the decremented count≠0, otherwise go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Reset values: state=IDLE, ready=1, running=0, data_out=0, done=0, count=0, timer=0.
- start is ignored outside IDLE; code_in is not sampled again mid-burst.
- code_in=0 produces no pulses: GUARD, then DONE, then IDLE.
- Reset asserted mid-burst forces IDLE immediately (asynchronous). data_out drops in the same cycle, and no done pulse is issued.
- Timer width is $clog2(max(HIGH_CYCLES, LOW_CYCLES, GUARD_CYCLES)+1). The count register is WIDTH bits, and decrement never wraps because the zero check precedes the decrement.

## Timing
Cycle indices below are relative to the accept edge E0 (the edge where start=1 and ready=1). Let P = HIGH_CYCLES+LOW_CYCLES.
- Cycle 1 onward: ready=0, running=1.
- Guard occupies cycles 1..GUARD_CYCLES.
- Pulse k (k = 1..N) is high for cycles GUARD_CYCLES + (k-1)·P + 1 through GUARD_CYCLES + (k-1)·P + HIGH_CYCLES.
- running deasserts after cycle GUARD_CYCLES + N·P.
- done is high in cycle GUARD_CYCLES + N·P + 1.
- ready is high again in cycle GUARD_CYCLES + N·P + 2. A start on that edge is accepted, so back-to-back bursts have a 2-cycle gap with data_out low.
- Total burst latency is deterministic and independent of the start pulse width.

## Structure
- Shared package (project logic include), constants:
  - state encoding localparams (3-bit: IDLE, GUARD, HIGH, LOW, DONE)
  - DEBOUNCE_MIN=3, used as the lower bound for HIGH_CYCLES and LOW_CYCLES
- One sub-module: phase_timer, a down-counter with synchronous load, load value input, and registered expire flag.
  - Asynchronous active-high reset to 0.
  - Instantiated once; the FSM selects the load value per state.
- Parameter checks run at elaboration: any parameter <1 is a fatal error.

## Test plan
All scenarios use default parameters (HIGH_CYCLES=LOW_CYCLES=4, GUARD_CYCLES=2).
- Reset: assert rst mid-cycle → ready=1, running=0, data_out=0, done=0 immediately, before the next clk edge.
- code_in=3, start for 1 cycle →
  - data_out high in cycles 3–6, 11–14, 19–22; running high in cycles 1–26;
  - done=1 in cycle 27 only; ready=1 in cycle 28;
  - exactly 3 rising edges on data_out.
- code_in=0 → no data_out activity; running high in cycles 1–2, done=1 in cycle 3, ready=1 in cycle 4.
- code_in=255 → 255 pulses, done in cycle 2043. Change code_in and pulse start during the burst → ignored; pulse count stays 255.
- Reset mid-burst: code_in=5, assert rst in cycle 13 (during pulse 2) → data_out=0 at once, no done pulse, ready=1.
  - Release rst, then code_in=2 → exactly 2 pulses and done in cycle 19.
- Back-to-back: start held high continuously with code_in=1 → bursts accepted every 12 cycles (guard 2 + pulse 8 + done 1 + idle 1), one pulse each.
